// File: rtl/demux_1_4_dist_pkg.sv
// Shared lane numbering and helpers for the 1:4 distributor and the 4:1 select mux.
// Both blocks use the same select encoding, so they agree on which lane is which.
package demux_1_4_dist_pkg;

  localparam int N_LANES = 4;
  localparam int SEL_W   = 2;

  typedef logic [SEL_W-1:0] lane_sel_t;

  localparam lane_sel_t LANE0 = 2'b00;
  localparam lane_sel_t LANE1 = 2'b01;
  localparam lane_sel_t LANE2 = 2'b10;
  localparam lane_sel_t LANE3 = 2'b11;

  function automatic logic [N_LANES-1:0] lane_onehot(input lane_sel_t sel);
    logic [N_LANES-1:0] oh;
    case (sel)
      LANE0:   oh = 4'b0001;
      LANE1:   oh = 4'b0010;
      LANE2:   oh = 4'b0100;
      LANE3:   oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_ptr_ctr.sv
// Round-robin lane pointer: 2-bit wrap counter with clear priority over increment.
// The wrap flag marks the increment that completes a four-lane frame.
module demux_ptr_ctr
  import demux_1_4_dist_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_en,
  input  logic      i_inc,
  input  logic      i_clr,
  output lane_sel_t o_ptr,
  output logic      o_wrap
);

  lane_sel_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_en) begin
      if (i_clr)      ptr_d = LANE0;
      else if (i_inc) ptr_d = ptr_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ptr_q <= LANE0;
    else       ptr_q <= ptr_d;
  end

  assign o_ptr  = ptr_q;
  assign o_wrap = i_en && i_inc && !i_clr && (ptr_q == LANE3);

endmodule

// File: rtl/demux_1_4_dist.sv
// 1:4 registered distributor: routes each accepted symbol into one lane, either by
// explicit select or round-robin; round-robin frames of four are captured into o_word.
module demux_1_4_dist
  import demux_1_4_dist_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_d,
  input  logic                       i_auto,
  input  logic [SEL_W-1:0]           i_sel_code,
  output logic [N_LANES*WIDTH-1:0]   o_code,
  output logic [N_LANES-1:0]         o_strb,
  output logic [N_LANES*WIDTH-1:0]   o_word,
  output logic                       o_word_vld,
  output logic [SEL_W-1:0]           o_ptr
);

  logic      accept;
  logic      wrap;
  lane_sel_t ptr;
  lane_sel_t lane;

  logic [N_LANES*WIDTH-1:0] code_q, code_d;
  logic [N_LANES-1:0]       strb_q, strb_d;
  logic [N_LANES*WIDTH-1:0] word_q, word_d;
  logic                     word_vld_q, word_vld_d;

  assign accept = i_en && i_valid;
  assign lane   = i_auto ? ptr : i_sel_code;

  // Manual accepts abort any partial round-robin frame.
  demux_ptr_ctr u_ptr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_inc  (accept && i_auto),
    .i_clr  (accept && !i_auto),
    .o_ptr  (ptr),
    .o_wrap (wrap)
  );

  always_comb begin
    code_d     = code_q;
    strb_d     = '0;
    word_d     = word_q;
    word_vld_d = 1'b0;
    if (accept) begin
      code_d[int'(lane)*WIDTH +: WIDTH] = i_d;
      strb_d = lane_onehot(lane);
      // Frame snapshot reflects the write happening on this same edge.
      if (wrap) begin
        word_d     = {i_d, code_q[3*WIDTH-1:0]};
        word_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      code_q     <= '0;
      strb_q     <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      code_q     <= code_d;
      strb_q     <= strb_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
    end
  end

  assign o_code     = code_q;
  assign o_strb     = strb_q;
  assign o_word     = word_q;
  assign o_word_vld = word_vld_q;
  assign o_ptr      = ptr;

endmodule

// File: tb/tb_demux_1_4_dist.sv
// Bench for demux_1_4_dist: directed scenarios plus random traffic, checked every cycle
// against a frame-queue model of the distributor.
module tb_demux_1_4_dist;

  localparam int WIDTH = 1;
  localparam int NL    = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en = 1'b0;
  logic                  valid = 1'b0;
  logic [WIDTH-1:0]      d = '0;
  logic                  auto_m = 1'b0;
  logic [1:0]            sel = 2'd0;
  logic [NL*WIDTH-1:0]   o_code;
  logic [NL-1:0]         o_strb;
  logic [NL*WIDTH-1:0]   o_word;
  logic                  o_word_vld;
  logic [1:0]            o_ptr;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  demux_1_4_dist #(.WIDTH(WIDTH)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_valid    (valid),
    .i_d        (d),
    .i_auto     (auto_m),
    .i_sel_code (sel),
    .o_code     (o_code),
    .o_strb     (o_strb),
    .o_word     (o_word),
    .o_word_vld (o_word_vld),
    .o_ptr      (o_ptr)
  );

  always #5 clk = ~clk;

  // Model: lanes as an array, the pending auto frame as a queue whose length is the pointer.
  logic [WIDTH-1:0]    m_lane [NL];
  logic [WIDTH-1:0]    m_q [$];
  logic [NL*WIDTH-1:0] m_word = '0;
  logic                m_vld  = 1'b0;
  logic [NL-1:0]       m_strb = '0;

  initial for (int k = 0; k < NL; k++) m_lane[k] = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NL; k++) m_lane[k] = '0;
      m_q.delete();
      m_word = '0;
      m_vld  = 1'b0;
      m_strb = '0;
    end else begin
      int tgt;
      m_strb = '0;
      m_vld  = 1'b0;
      if (en && valid) begin
        if (auto_m) begin
          tgt = m_q.size();
          m_q.push_back(d);
          if (m_q.size() == NL) begin
            for (int k = 0; k < NL; k++) m_word[k*WIDTH +: WIDTH] = m_q[k];
            m_vld = 1'b1;
            m_q.delete();
          end
        end else begin
          tgt = int'(sel);
          m_q.delete();
        end
        m_lane[tgt] = d;
        m_strb = NL'(1) << tgt;
      end
    end
  end

  function automatic logic [NL*WIDTH-1:0] m_code();
    logic [NL*WIDTH-1:0] c;
    for (int k = 0; k < NL; k++) c[k*WIDTH +: WIDTH] = m_lane[k];
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_code", 32'(o_code), 32'(m_code()));
      chk("cyc_strb", 32'(o_strb), 32'(m_strb));
      chk("cyc_word", 32'(o_word), 32'(m_word));
      chk("cyc_wvld", 32'(o_word_vld), 32'(m_vld));
      chk("cyc_ptr",  32'(o_ptr), 32'(m_q.size()));
    end
  end

  task automatic step(input logic e, input logic v, input logic [WIDTH-1:0] dd,
                      input logic a, input logic [1:0] s);
    @(negedge clk);
    en = e; valid = v; d = dd; auto_m = a; sel = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    #1;
    chk("rst_code", 32'(o_code), 32'h0);
    chk("rst_ptr",  32'(o_ptr), 32'h0);
    chk("rst_wvld", 32'(o_word_vld), 32'h0);

    // Manual routing to lane 2
    step(1, 1, 1, 0, 2);
    chk("man_code", 32'(o_code), 32'b0100);
    chk("man_strb", 32'(o_strb), 32'b0100);
    step(1, 0, 0, 0, 0);
    chk("man_strb_clr", 32'(o_strb), 32'b0000);

    // Auto frame 1,0,1,1
    step(1, 1, 1, 1, 0); chk("af_ptr1", 32'(o_ptr), 32'd1);
    step(1, 1, 0, 1, 0); chk("af_ptr2", 32'(o_ptr), 32'd2);
    step(1, 1, 1, 1, 0); chk("af_ptr3", 32'(o_ptr), 32'd3);
    step(1, 1, 1, 1, 0); chk("af_ptr0", 32'(o_ptr), 32'd0);
    chk("af_word", 32'(o_word), 32'b1101);
    chk("af_wvld", 32'(o_word_vld), 32'd1);
    chk("model_word", 32'(m_word), 32'b1101);
    step(1, 0, 0, 1, 0);
    chk("af_wvld_clr", 32'(o_word_vld), 32'd0);
    chk("af_word_hold", 32'(o_word), 32'b1101);

    // Enable gating mid-frame
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, 0);
      chk("eg_ptr", 32'(o_ptr), 32'd2);
      chk("eg_strb", 32'(o_strb), 32'd0);
    end
    step(1, 1, 0, 1, 0);
    chk("eg_wvld_early", 32'(o_word_vld), 32'd0);
    step(1, 1, 0, 1, 0);
    chk("eg_wvld", 32'(o_word_vld), 32'd1);
    chk("eg_word", 32'(o_word), 32'b0011);

    // Manual abort with ptr=2
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    chk("ab_ptr_pre", 32'(o_ptr), 32'd2);
    step(1, 1, 1, 0, 0);
    chk("ab_ptr", 32'(o_ptr), 32'd0);
    chk("ab_wvld", 32'(o_word_vld), 32'd0);
    chk("ab_word", 32'(o_word), 32'b0011);

    // Eight back-to-back auto accepts alternating 1,0
    for (int i = 0; i < 8; i++) begin
      step(1, 1, WIDTH'((i % 2 == 0) ? 1 : 0), 1, 0);
      chk("bb_wvld", 32'(o_word_vld), 32'((i % 4) == 3));
      if (i % 4 == 3) chk("bb_word", 32'(o_word), 32'b0101);
    end
    chk("model_word_bb", 32'(m_word), 32'b0101);

    // Build o_code=1011 and ptr=2, then reset between edges
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 1);
    step(1, 1, 0, 0, 2);
    step(1, 1, 1, 0, 3);
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    chk("mr_code_pre", 32'(o_code), 32'b1011);
    chk("mr_ptr_pre", 32'(o_ptr), 32'd2);
    @(negedge clk);
    en = 1'b0; valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mr_code", 32'(o_code), 32'h0);
    chk("mr_ptr", 32'(o_ptr), 32'h0);
    chk("mr_word", 32'(o_word), 32'h0);
    chk("mr_strb", 32'(o_strb), 32'h0);
    #1 rst = 1'b0;
    step(1, 1, 1, 1, 0);
    chk("mr_next_code", 32'(o_code), 32'b0001);
    chk("mr_next_strb", 32'(o_strb), 32'b0001);
    chk("mr_next_ptr", 32'(o_ptr), 32'd1);

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      en     = ($urandom_range(0, 9) != 0);
      valid  = ($urandom_range(0, 3) != 0);
      d      = WIDTH'($urandom);
      auto_m = ($urandom_range(0, 4) != 0);
      sel    = 2'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      @(posedge clk);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
